// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter : iterative 32-bit radix-2 restoring divider for the EX stage.
//
// Serves DIV (signed, two's complement) and DIVU (unsigned). Operands are
// latched when EX issues a start. One quotient bit is produced per cycle.
// While the result is pending, EX is held through stallreq.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active low (0 = reset)
//   div_start   EX requests a divide; held high until EX sees ready
//   signed_div  1 = DIV, 0 = DIVU; sampled with div_start
//   dividend    numerator, sampled only at accept
//   divisor     denominator, sampled only at accept
//   annul       instruction in EX squashed; aborts any operation
//   result      {remainder[63:32], quotient[31:0]} = {HI, LO}
//   ready       result valid (held while div_start stays high)
//   busy        registered: state is not FREE
//   stallreq    div_start & ~ready (the only combinational output)
// -----------------------------------------------------------------------------
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_start,
  input  logic        signed_div,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        busy,
  output logic        stallreq
);

  typedef enum logic [1:0] {
    FREE        = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } state_e;

  state_e      state_q,    state_d;
  logic [4:0]  cnt_q,      cnt_d;
  // {partial remainder, dividend/quotient}. The partial remainder is always
  // below the divisor magnitude, so the 33-bit trial operand is simply the
  // top 33 bits of this register and no separate 65th bit needs storing.
  logic [63:0] work_q,     work_d;
  logic [31:0] dvsr_q,     dvsr_d;      // |divisor|
  logic        sgn_q,      sgn_d;       // latched signed_div
  logic        dvd_neg_q,  dvd_neg_d;   // dividend sign at accept
  logic        dvs_neg_q,  dvs_neg_d;   // divisor sign at accept
  logic [63:0] result_q,   result_d;
  logic        ready_q,    ready_d;

  // Operand magnitudes at accept. 0x80000000 negates to itself, which is the
  // correct unsigned magnitude.
  logic [31:0] dvd_abs;
  logic [31:0] dvs_abs;

  // One restoring step and the sign fix-up of its outcome.
  logic [32:0] trial;
  logic [63:0] work_next;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch can be inferred.
  always_comb begin
    dvd_abs = (signed_div && dividend[31]) ? (32'd0 - dividend) : dividend;
    dvs_abs = (signed_div && divisor[31])  ? (32'd0 - divisor)  : divisor;

    trial = work_q[63:31] - {1'b0, dvsr_q};
    if (trial[32]) begin
      // Negative trial: restore, quotient bit 0.
      work_next = {work_q[62:0], 1'b0};
    end else begin
      // Non-negative trial: keep the difference, quotient bit 1.
      work_next = {trial[31:0], work_q[30:0], 1'b1};
    end

    quo_fix = work_next[31:0];
    rem_fix = work_next[63:32];
    if (sgn_q && (dvd_neg_q ^ dvs_neg_q)) begin
      quo_fix = 32'd0 - work_next[31:0];
    end
    if (sgn_q && dvd_neg_q) begin
      rem_fix = 32'd0 - work_next[63:32];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    dvsr_d    = dvsr_q;
    sgn_d     = sgn_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      FREE: begin
        if (div_start) begin
          sgn_d     = signed_div;
          dvd_neg_d = dividend[31];
          dvs_neg_d = divisor[31];
          if (divisor == 32'd0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            dvsr_d  = dvs_abs;
            work_d  = {32'd0, dvd_abs};
            cnt_d   = 5'd0;
            state_d = DIV_ON;
          end
        end
      end

      DIV_BY_ZERO: begin
        state_d  = DIV_END;
        result_d = 64'd0;
        ready_d  = 1'b1;
      end

      DIV_ON: begin
        // div_start is deliberately ignored here; only annul aborts.
        work_d = work_next;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d  = DIV_END;
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
        end
      end

      DIV_END: begin
        // Result is held until EX drops its request.
        if (!div_start) begin
          state_d  = FREE;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end
      end

      default: begin
        state_d = FREE;
      end
    endcase

    // A squashed instruction wins over everything except reset, including
    // an accept in FREE.
    if (annul) begin
      state_d  = FREE;
      cnt_d    = 5'd0;
      result_d = 64'd0;
      ready_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FREE;
      cnt_q     <= 5'd0;
      work_q    <= 64'd0;
      dvsr_q    <= 32'd0;
      sgn_q     <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      result_q  <= 64'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      dvsr_q    <= dvsr_d;
      sgn_q     <= sgn_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result   = result_q;
  assign ready    = ready_q;
  assign busy     = (state_q != FREE);
  assign stallreq = div_start & ~ready_q;

endmodule
